mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
// - Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// - Sits beside the register file in the execute stage.
// - Takes the two register-file read ports (rs, rt) as operands.
// - Results are read back through MFHI/MFLO into the register-file write port.
// - Raises stall when the pipeline needs HI/LO or issues a new op while busy.
// PARAMETERS
// - XLEN   32  operand/result width.
// - CNT_W  6   iteration counter width; must satisfy 2**CNT_W > XLEN.
// PORTS
// - clk          in   1     clock; all state updates on posedge.
// - reset        in   1     asynchronous, active-high.
// - start        in   1     launch op; sampled only in IDLE.
// - op           in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
// - src_a        in   XLEN  rs operand (multiplicand/dividend); MTHI/MTLO data.
// - src_b        in   XLEN  rt operand (multiplier/divisor).
// - mthi         in   1     write src_a to HI (IDLE only).
// - mtlo         in   1     write src_a to LO (IDLE only).
// - rd_hilo_req  in   1     current instruction is MFHI/MFLO.
// - hi           out  XLEN  HI register.
// - lo           out  XLEN  LO register.
// - busy         out  1     1 while state != IDLE.
// - done         out  1     one-cycle pulse when hi/lo receive a result.
// - stall        out  1     combinational: busy & (start | rd_hilo_req | mthi | mtlo).
// BEHAVIOUR
// - Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
// - FSM IDLE -> RUN -> FIX -> IDLE.
// - Edge E0, IDLE & start: latch op, |src_a|, |src_b| (signed ops) or raw (unsigned); save result signs; go RUN.
// - RUN, edges E1..E32: one iteration per edge.
//   - Multiply: shift-add.
//   - Divide: restoring shift-subtract.
//   - Counter reaches XLEN-1 at E32 -> FIX.
// - FIX, edge E33: sign-correct, write hi/lo, done=1, go IDLE.
// - Edge E34: done=0. Latency start->result = 33 edges.
// - Divide results: quotient -> LO, remainder -> HI.
//   - Signed quotient truncates toward zero.
//   - Remainder takes the dividend's sign.
// - Divide by zero: HI=dividend, LO=all ones; still 33 edges.
// - Signed 0x80000000 / -1: LO=0x80000000, HI=0.
// - start while busy: ignored; no queuing.
// - mthi/mtlo in IDLE: update on next edge, done stays 0.
// - mthi/mtlo while busy: ignored.
// - start with mthi/mtlo on the same edge: start wins; move is dropped.
// - hi/lo hold their old values throughout RUN.
// - Reset mid-op: abort immediately; no done pulse.
// STRUCTURE
// - Shared package mips_pkg:
//   - md_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
//   - XLEN constant.
//   - md_state_t (IDLE, RUN, FIX).
// - One sub-module md_iter_core: 2*XLEN accumulator/remainder datapath; one step per enable.
// - FSM, counter, sign handling and HI/LO registers stay in the top.
// TESTING
// - MULT 0xFFFFFFFD x 0x7 -> at E33 HI=0xFFFFFFFF, LO=0xFFFFFFEB; done high exactly 1 cycle.
// - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
// - DIV 0xFFFFFFF9 / 0x2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   - DIVU 7/2 -> LO=3, HI=1.
// - DIV 5/0 -> HI=5, LO=0xFFFFFFFF.
//   - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
// - Busy behaviour: start at E5 ignored; rd_hilo_req at E10 -> stall=1, busy=1.
//   - Reset at E12 -> busy=0, hi=lo=0, no done.
// - MTHI src_a=0x1234 in IDLE -> hi=0x1234 next edge.
//   - MTLO concurrent with start -> lo unchanged until E33.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage types and constants.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef logic [1:0] md_state_t;

    localparam md_state_t IDLE = 2'd0;
    localparam md_state_t RUN  = 2'd1;
    localparam md_state_t FIX  = 2'd2;

endpackage

// File: rtl/md_iter_core.sv
// Unsigned multiply/divide datapath: one shift-add or restoring shift-subtract step per enable.
module md_iter_core #(
    parameter int unsigned XLEN = mips_pkg::XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic              is_div_q, is_div_d;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_sub;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_sub  = rem_sh[XLEN-1:0] - opd_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        if (load_i) begin
            is_div_d = is_div_i;
            opd_d    = is_div_i ? b_i : a_i;
            acc_d    = {{XLEN{1'b0}}, (is_div_i ? a_i : b_i)};
        end else if (step_i) begin
            if (is_div_q) begin
                if (rem_sh >= {1'b0, opd_q}) begin
                    acc_d = {rem_sub, acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
            end else if (acc_q[0]) begin
                acc_d = {sum, acc_q[XLEN-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
module mult_div_unit #(
    parameter int unsigned XLEN  = mips_pkg::XLEN,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic            rd_hilo_req,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            stall
);
    import mips_pkg::*;

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;
    logic              is_div_q, res_neg_q, rem_neg_q, div_zero_q;

    md_op_t            op_in;
    logic              launch, is_signed_in, is_div_in, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN-1:0]   quo, rem, res_hi, res_lo;

    always_comb begin
        op_in        = md_op_t'(op);
        launch       = (state_q == IDLE) && start;
        is_signed_in = (op_in == MD_MULT) || (op_in == MD_DIV);
        is_div_in    = (op_in == MD_DIV) || (op_in == MD_DIVU);
        a_neg        = is_signed_in && src_a[XLEN-1];
        b_neg        = is_signed_in && src_b[XLEN-1];
        a_mag        = a_neg ? -src_a : src_a;
        b_mag        = b_neg ? -src_b : src_b;
    end

    md_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (launch),
        .step_i   (state_q == RUN),
        .is_div_i (is_div_in),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .acc_o    (acc)
    );

    // Divide by zero leaves |dividend| in the remainder, so only LO needs forcing.
    always_comb begin
        prod = res_neg_q ? -acc : acc;
        quo  = acc[XLEN-1:0];
        rem  = acc[2*XLEN-1:XLEN];
        if (is_div_q) begin
            res_lo = div_zero_q ? '1 : (res_neg_q ? -quo : quo);
            res_hi = rem_neg_q ? -rem : rem;
        end else begin
            res_lo = prod[XLEN-1:0];
            res_hi = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    if (mthi) hi_d = src_a;
                    if (mtlo) lo_d = src_a;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (launch) begin
            is_div_q   <= is_div_in;
            res_neg_q  <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            div_zero_q <= (src_b == '0);
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);
    assign stall = busy && (start || rd_hilo_req || mthi || mtlo);

endmodule
